mnk_game_engine: RTL and testbench

MNK_GAME_ENGINE -- requirements
Module: mnk_game_engine

---
 rtl/mnk_game_engine_pkg.sv | 28 ++
 rtl/mnk_line_counter.sv | 60 ++++++
 rtl/mnk_game_engine.sv | 177 +++++++++++++++++
 tb/tb_mnk_game_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mnk_game_engine_pkg.sv
// Shared encodings for the m,n,k game engine: cell values, FSM states, scan directions.
package mnk_game_engine_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      P1    = 2'b01,
      P2    = 2'b10
   } cell_e;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      RESULT,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      DIR_H,
      DIR_V,
      DIR_D,
      DIR_A
   } dir_e;

   function automatic logic [1:0] other_player(input logic [1:0] p);
      return (p == P1) ? P2 : P1;
   endfunction

endpackage

// File: rtl/mnk_line_counter.sv
// Combinational run-length of one player's stones through an origin cell along one direction.
// The window reaches WIN_LEN-1 cells each side and stops at the first foreign cell or board edge.
module mnk_line_counter
   import mnk_game_engine_pkg::*;
#(
   parameter int ROWS    = 3,
   parameter int COLS    = 3,
   parameter int WIN_LEN = 3,
   parameter int RW      = 2,
   parameter int CW      = 2,
   parameter int CNT_W   = 3
) (
   input  logic [2*ROWS*COLS-1:0] board_i,
   input  logic [RW-1:0]          row_i,
   input  logic [CW-1:0]          col_i,
   input  dir_e                   dir_i,
   input  logic [1:0]             player_i,
   output logic [CNT_W-1:0]       count_o
);

   int   dr;
   int   dc;
   int   r;
   int   c;
   int   cnt;
   logic run;

   always_comb begin
      dr  = 0;
      dc  = 1;
      cnt = 1;
      r   = 0;
      c   = 0;
      run = 1'b0;
      case (dir_i)
         DIR_V:   begin dr = 1; dc = 0;  end
         DIR_D:   begin dr = 1; dc = 1;  end
         DIR_A:   begin dr = 1; dc = -1; end
         default: begin dr = 0; dc = 1;  end
      endcase
      // s=0 walks forward along (dr,dc), s=1 walks backward
      for (int s = 0; s < 2; s++) begin
         run = 1'b1;
         for (int k = 1; k < WIN_LEN; k++) begin
            r = (s == 0) ? int'(row_i) + k * dr : int'(row_i) - k * dr;
            c = (s == 0) ? int'(col_i) + k * dc : int'(col_i) - k * dc;
            if (run) begin
               if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
                  if (board_i[2*(r*COLS+c) +: 2] == player_i) cnt = cnt + 1;
                  else run = 1'b0;
               end else begin
                  run = 1'b0;
               end
            end
         end
      end
      count_o = CNT_W'(cnt);
   end

endmodule

// File: rtl/mnk_game_engine.sv
// m,n,k game referee: validates moves, places stones, scans four directions for a win, reports draw.
// Illegal moves answer one cycle after acceptance, legal ones five cycles after.
module mnk_game_engine
   import mnk_game_engine_pkg::*;
#(
   parameter int ROWS    = 3,
   parameter int COLS    = 3,
   parameter int WIN_LEN = 3
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             new_game,
   input  logic                             move_valid,
   output logic                             move_ready,
   input  logic [1:0]                       move_player,
   input  logic [$clog2(ROWS)-1:0]          move_row,
   input  logic [$clog2(COLS)-1:0]          move_col,
   output logic                             resp_valid,
   output logic                             resp_illegal,
   output logic [2*ROWS*COLS-1:0]           board,
   output logic [1:0]                       turn,
   output logic [1:0]                       winner,
   output logic                             game_over,
   output logic [$clog2(ROWS*COLS+1)-1:0]   move_count
);

   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int CELLS = ROWS * COLS;
   localparam int MC_W  = $clog2(CELLS + 1);
   localparam int CNT_W = $clog2(2 * WIN_LEN);

   state_e             state_q, state_d;
   logic [2*CELLS-1:0] board_q, board_d;
   logic [1:0]         player_q, player_d;
   logic [RW-1:0]      row_q, row_d;
   logic [CW-1:0]      col_q, col_d;
   logic               illegal_q, illegal_d;
   logic               win_q, win_d;
   dir_e               dir_q, dir_d;
   logic [1:0]         turn_q, turn_d;
   logic [1:0]         winner_q, winner_d;
   logic               game_over_q, game_over_d;
   logic [MC_W-1:0]    mc_q, mc_d;

   logic [CNT_W-1:0]   line_cnt;
   logic               in_range;
   logic               legal;
   int                 cell_idx;

   mnk_line_counter #(
      .ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN), .RW(RW), .CW(CW), .CNT_W(CNT_W)
   ) u_line_counter (
      .board_i (board_q),
      .row_i   (row_q),
      .col_i   (col_q),
      .dir_i   (dir_q),
      .player_i(player_q),
      .count_o (line_cnt)
   );

   always_comb begin
      in_range = (32'(move_row) < ROWS) && (32'(move_col) < COLS);
      cell_idx = int'(move_row) * COLS + int'(move_col);
      legal    = 1'b0;
      // cell is only read once the coordinates are known to be on the board
      if (in_range && (move_player == P1 || move_player == P2) && move_player == turn_q)
         legal = (board_q[2*cell_idx +: 2] == EMPTY);
   end

   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      player_d    = player_q;
      row_d       = row_q;
      col_d       = col_q;
      illegal_d   = illegal_q;
      win_d       = win_q;
      dir_d       = dir_q;
      turn_d      = turn_q;
      winner_d    = winner_q;
      game_over_d = game_over_q;
      mc_d        = mc_q;
      case (state_q)
         IDLE: begin
            if (move_valid) begin
               player_d  = move_player;
               row_d     = move_row;
               col_d     = move_col;
               illegal_d = ~legal;
               win_d     = 1'b0;
               dir_d     = DIR_H;
               if (legal) begin
                  board_d[2*cell_idx +: 2] = move_player;
                  mc_d    = mc_q + 1'b1;
                  state_d = CHECK;
               end else begin
                  state_d = RESULT;
               end
            end
         end
         CHECK: begin
            if (line_cnt >= CNT_W'(WIN_LEN)) win_d = 1'b1;
            if (dir_q == DIR_A) state_d = RESULT;
            else                dir_d   = dir_e'(dir_q + 2'd1);
         end
         RESULT: begin
            if (illegal_q) begin
               state_d = IDLE;
            end else if (win_q) begin
               winner_d    = player_q;
               game_over_d = 1'b1;
               state_d     = DONE;
            end else if (mc_q == MC_W'(CELLS)) begin
               game_over_d = 1'b1;
               state_d     = DONE;
            end else begin
               turn_d  = other_player(turn_q);
               state_d = IDLE;
            end
         end
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
      // a new game wins over everything, including a move still being scanned
      if (new_game) begin
         state_d     = IDLE;
         board_d     = '0;
         turn_d      = P1;
         winner_d    = EMPTY;
         game_over_d = 1'b0;
         mc_d        = '0;
         win_d       = 1'b0;
         dir_d       = DIR_H;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         board_q     <= '0;
         player_q    <= EMPTY;
         row_q       <= '0;
         col_q       <= '0;
         illegal_q   <= 1'b0;
         win_q       <= 1'b0;
         dir_q       <= DIR_H;
         turn_q      <= P1;
         winner_q    <= EMPTY;
         game_over_q <= 1'b0;
         mc_q        <= '0;
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         player_q    <= player_d;
         row_q       <= row_d;
         col_q       <= col_d;
         illegal_q   <= illegal_d;
         win_q       <= win_d;
         dir_q       <= dir_d;
         turn_q      <= turn_d;
         winner_q    <= winner_d;
         game_over_q <= game_over_d;
         mc_q        <= mc_d;
      end
   end

   assign move_ready   = (state_q == IDLE);
   assign resp_valid   = (state_q == RESULT);
   assign resp_illegal = (state_q == RESULT) && illegal_q;
   assign board        = board_q;
   assign turn         = turn_q;
   assign winner       = winner_q;
   assign game_over    = game_over_q;
   assign move_count   = mc_q;

endmodule

// File: tb/tb_mnk_game_engine.sv
// Directed bench: a 3x3/3 engine and a 15x15/5 engine share clock, reset and new_game; sel picks the one driven.
module tb_mnk_game_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, new_game, mv, sel;
   logic [1:0] pl;
   logic [3:0] row, col;

   logic        a_ready, a_rv, a_ri, a_go;
   logic [17:0] a_board;
   logic [1:0]  a_turn, a_winner;
   logic [3:0]  a_mc;

   logic         b_ready, b_rv, b_ri, b_go;
   logic [449:0] b_board;
   logic [1:0]   b_turn, b_winner;
   logic [7:0]   b_mc;

   logic       cur_ready, cur_rv, cur_ri, cur_go;
   logic [1:0] cur_turn, cur_winner;
   logic [7:0] cur_mc;

   int checks   = 0;
   int failures = 0;

   logic [17:0]  exp_a;
   logic [449:0] exp_b;

   mnk_game_engine dut (
      .clock(clk), .reset_n(rst_n), .new_game(new_game),
      .move_valid(mv && !sel), .move_ready(a_ready), .move_player(pl),
      .move_row(row[1:0]), .move_col(col[1:0]),
      .resp_valid(a_rv), .resp_illegal(a_ri), .board(a_board), .turn(a_turn),
      .winner(a_winner), .game_over(a_go), .move_count(a_mc)
   );

   mnk_game_engine #(.ROWS(15), .COLS(15), .WIN_LEN(5)) dut15 (
      .clock(clk), .reset_n(rst_n), .new_game(new_game),
      .move_valid(mv && sel), .move_ready(b_ready), .move_player(pl),
      .move_row(row), .move_col(col),
      .resp_valid(b_rv), .resp_illegal(b_ri), .board(b_board), .turn(b_turn),
      .winner(b_winner), .game_over(b_go), .move_count(b_mc)
   );

   assign cur_ready  = sel ? b_ready  : a_ready;
   assign cur_rv     = sel ? b_rv     : a_rv;
   assign cur_ri     = sel ? b_ri     : a_ri;
   assign cur_go     = sel ? b_go     : a_go;
   assign cur_turn   = sel ? b_turn   : a_turn;
   assign cur_winner = sel ? b_winner : a_winner;
   assign cur_mc     = sel ? b_mc     : {4'b0, a_mc};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // drives one request, measures response latency, returns #1 after the edge leaving RESULT
   task automatic move(input string tag, input logic [1:0] p, input int r, input int c,
                       input logic exp_ill);
      int   lat;
      logic ill;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(cur_ready), 1);
      mv  = 1'b1;
      pl  = p;
      row = 4'(r);
      col = 4'(c);
      @(posedge clk);
      #1;
      mv  = 1'b0;
      lat = 1;
      while (!cur_rv && lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
      end
      ill = cur_ri;
      chk({tag, "_lat"}, 32'(lat), exp_ill ? 1 : 5);
      chk({tag, "_ill"}, 32'(ill), 32'(exp_ill));
      if (!exp_ill) begin
         if (sel) exp_b[2*(r*15+c) +: 2] = p;
         else     exp_a[2*(r*3+c) +: 2]  = p;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_new_game();
      @(negedge clk);
      new_game = 1'b1;
      @(posedge clk);
      #1;
      new_game = 1'b0;
      exp_a = '0;
      exp_b = '0;
   endtask

   task automatic watch_no_resp(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (a_rv || b_rv) seen = 1'b1;
      end
      chk(tag, 32'(seen), 0);
   endtask

   initial begin
      rst_n = 1'b0; new_game = 1'b0; mv = 1'b0; sel = 1'b0;
      pl = 2'b00; row = '0; col = '0;
      exp_a = '0; exp_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_board",  32'(a_board), 0);
      chk("rst_turn",   32'(a_turn), 1);
      chk("rst_winner", 32'(a_winner), 0);
      chk("rst_go",     32'(a_go), 0);
      chk("rst_mc",     32'(a_mc), 0);
      chk("rst_rv",     32'(a_rv), 0);
      chk("rst_ri",     32'(a_ri), 0);
      chk("rst_ready",  32'(a_ready), 1);
      chk("rst_b_board", 32'(b_board === '0), 1);

      // row 0 win for player 1
      move("w1", 2'b01, 0, 0, 1'b0);
      chk("w1_turn", 32'(cur_turn), 2);
      move("w2", 2'b10, 1, 0, 1'b0);
      chk("w2_turn", 32'(cur_turn), 1);
      move("w3", 2'b01, 0, 1, 1'b0);
      move("w4", 2'b10, 1, 1, 1'b0);
      chk("w4_go", 32'(cur_go), 0);
      move("w5", 2'b01, 0, 2, 1'b0);
      chk("win_winner", 32'(cur_winner), 1);
      chk("win_go",     32'(cur_go), 1);
      chk("win_ready",  32'(cur_ready), 0);
      chk("win_mc",     32'(cur_mc), 5);
      chk("win_board",  32'(a_board), 32'(exp_a));

      // requests held while the game is over are ignored
      @(negedge clk);
      mv = 1'b1; pl = 2'b10; row = 4'd2; col = 4'd2;
      watch_no_resp("done_no_resp", 10);
      mv = 1'b0;
      chk("done_board", 32'(a_board), 32'(exp_a));
      chk("done_ready", 32'(a_ready), 0);

      start_new_game();
      chk("ng_board", 32'(a_board), 0);
      chk("ng_ready", 32'(a_ready), 1);
      chk("ng_winner", 32'(a_winner), 0);
      chk("ng_go", 32'(a_go), 0);

      // illegal requests leave state untouched
      move("il1", 2'b01, 1, 1, 1'b0);
      move("il_occ", 2'b10, 1, 1, 1'b1);
      chk("il_occ_mc", 32'(cur_mc), 1);
      chk("il_occ_turn", 32'(cur_turn), 2);
      move("il_turn", 2'b01, 0, 0, 1'b1);
      move("il_p11", 2'b11, 0, 0, 1'b1);
      move("il_row", 2'b10, 3, 0, 1'b1);
      move("il_col", 2'b10, 0, 3, 1'b1);
      chk("il_mc", 32'(cur_mc), 1);
      chk("il_turn2", 32'(cur_turn), 2);
      chk("il_board", 32'(a_board), 32'(exp_a));

      // nine moves, no three in a line
      start_new_game();
      move("d1", 2'b01, 0, 0, 1'b0);
      move("d2", 2'b10, 0, 1, 1'b0);
      move("d3", 2'b01, 0, 2, 1'b0);
      move("d4", 2'b10, 1, 1, 1'b0);
      move("d5", 2'b01, 1, 0, 1'b0);
      move("d6", 2'b10, 2, 0, 1'b0);
      move("d7", 2'b01, 1, 2, 1'b0);
      move("d8", 2'b10, 2, 2, 1'b0);
      chk("d8_go", 32'(cur_go), 0);
      move("d9", 2'b01, 2, 1, 1'b0);
      chk("draw_go", 32'(cur_go), 1);
      chk("draw_winner", 32'(cur_winner), 0);
      chk("draw_mc", 32'(cur_mc), 9);
      chk("draw_ready", 32'(cur_ready), 0);
      chk("draw_board", 32'(a_board), 32'(exp_a));

      // new_game during the second scan cycle
      start_new_game();
      @(negedge clk);
      mv = 1'b1; pl = 2'b01; row = 4'd0; col = 4'd0;
      @(posedge clk);
      #1;
      mv = 1'b0;
      @(posedge clk);
      #1;
      new_game = 1'b1;
      @(posedge clk);
      #1;
      new_game = 1'b0;
      chk("abort_ng_board", 32'(a_board), 0);
      chk("abort_ng_ready", 32'(a_ready), 1);
      chk("abort_ng_mc", 32'(a_mc), 0);
      watch_no_resp("abort_ng_no_resp", 6);

      // reset during the second scan cycle
      @(negedge clk);
      mv = 1'b1; pl = 2'b01; row = 4'd1; col = 4'd2;
      @(posedge clk);
      #1;
      mv = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_rst_board", 32'(a_board), 0);
      chk("abort_rst_ready", 32'(a_ready), 1);
      chk("abort_rst_mc", 32'(a_mc), 0);
      chk("abort_rst_rv", 32'(a_rv), 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_a = '0;
      exp_b = '0;
      watch_no_resp("abort_rst_no_resp", 6);

      // 15x15, five in a row: player 2 anti-diagonal completed from the middle
      sel = 1'b1;
      move("b1", 2'b01, 0, 0, 1'b0);
      move("b2", 2'b10, 4, 10, 1'b0);
      move("b3", 2'b01, 0, 2, 1'b0);
      move("b4", 2'b10, 5, 9, 1'b0);
      move("b5", 2'b01, 0, 4, 1'b0);
      move("b6", 2'b10, 7, 7, 1'b0);
      move("b7", 2'b01, 0, 6, 1'b0);
      move("b8", 2'b10, 8, 6, 1'b0);
      move("b9", 2'b01, 0, 8, 1'b0);
      chk("b9_go", 32'(cur_go), 0);
      move("b10", 2'b10, 6, 8, 1'b0);
      chk("anti_winner", 32'(cur_winner), 2);
      chk("anti_go", 32'(cur_go), 1);
      chk("anti_board", 32'(b_board === exp_b), 1);

      // four stones against the right edge are not a win
      start_new_game();
      move("e1", 2'b01, 14, 11, 1'b0);
      move("e2", 2'b10, 0, 0, 1'b0);
      move("e3", 2'b01, 14, 12, 1'b0);
      move("e4", 2'b10, 0, 2, 1'b0);
      move("e5", 2'b01, 14, 13, 1'b0);
      move("e6", 2'b10, 0, 4, 1'b0);
      move("e7", 2'b01, 14, 14, 1'b0);
      chk("edge_go", 32'(cur_go), 0);
      chk("edge_winner", 32'(cur_winner), 0);
      chk("edge_turn", 32'(cur_turn), 2);
      chk("edge_mc", 32'(cur_mc), 7);
      chk("edge_board", 32'(b_board === exp_b), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
